// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
//   NUM_COLS / NUM_ROWS : matrix geometry
//   COL_IDLE            : column strobe pattern at reset (column 0 driven low)
//   KEY_TABLE           : key index (col*4 + row) to hex value, 4 bits per entry
//   key_hex()           : table lookup
//   lowest_set()        : index of the lowest set bit of a 16-bit key frame
//   map_keys()          : converts an index-ordered frame into a hex-ordered key map
package kypd_pkg;

    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_KEYS = NUM_COLS * NUM_ROWS;

    localparam logic [3:0] COL_IDLE = 4'b1110;

    // Entry i sits at bits [4*i +: 4]; reading each group MSB-first gives
    // rows 3..0 of columns 3..0 (col 0 = 1,4,7,0 with row 0 on top).
    localparam logic [63:0] KEY_TABLE = 64'hDCBA_E963_F852_0741;

    typedef enum logic [1:0] {
        COL0,
        COL1,
        COL2,
        COL3
    } col_t;

    function automatic logic [3:0] key_hex(input logic [3:0] idx);
        return KEY_TABLE[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] r;
        logic       found;
        r     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (v[i] && !found) begin
                r     = 4'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] map_keys(input logic [15:0] f);
        logic [15:0] m;
        m = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (f[i]) m[key_hex(4'(i))] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key event bus from the keypad scanner to its consumer.
//   key_code  : hex value of the most recent newly pressed key
//   key_valid : one-cycle pulse, key_code is new on this cycle
//   key_down  : any key held in the accepted frame
//   pressed   : accepted key map, bit k = key with hex value k held
// master = scanner side (drives), slave = consumer side.
interface keypad_scanner_if;

    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] pressed;

    modport master (output key_code, key_valid, key_down, pressed);
    modport slave  (input  key_code, key_valid, key_down, pressed);

endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// Generic N-bit two-flop synchronizer for asynchronous inputs.
//   clk : destination clock
//   rst : synchronous active-high reset, clears both stages
//   d   : asynchronous input
//   q   : synchronized output (two cycles of latency)
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with full-frame debounce.
// Strobes one column low at a time for SCAN_DIV cycles, samples the rows at
// the end of each dwell, and accepts a 16-key frame once DEBOUNCE_SCANS
// consecutive frames agree. Newly pressed keys in an accepted frame raise a
// one-cycle event carrying the hex value of the lowest key index.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   row  : keypad rows, active-low, asynchronous
//   col  : column strobes, active-low, one bit low at a time
//   kbus : key event bus (key_code, key_valid, key_down, pressed)
module keypad_scanner
    import kypd_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          row,
    output logic [3:0]          col,
    keypad_scanner_if.master    kbus
);

    localparam int unsigned DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned MATCH_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(DEBOUNCE_SCANS - 1);

    logic [3:0]         row_sync;
    logic [3:0]         row_act;
    logic [DIV_W-1:0]   div;
    logic               tc;
    col_t               col_idx;
    col_t               col_next;
    logic [15:0]        raw;
    logic [15:0]        prev;
    logic [15:0]        acc;
    logic               frame_done;
    logic [MATCH_W-1:0] match;
    logic [MATCH_W-1:0] match_next;
    logic               accept;
    logic [15:0]        new_keys;

    sync_2ff #(.WIDTH(NUM_ROWS)) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row),
        .q   (row_sync)
    );

    assign row_act = ~row_sync;
    assign tc      = (div == DIV_LAST);

    // Column sequencer
    always_ff @(posedge clk) begin
        if (rst) col_idx <= COL0;
        else     col_idx <= col_next;
    end

    always_comb begin
        col_next = col_idx;
        if (tc) begin
            case (col_idx)
                COL0:    col_next = COL1;
                COL1:    col_next = COL2;
                COL2:    col_next = COL3;
                default: col_next = COL0;
            endcase
        end
    end

    always_comb begin
        case (col_idx)
            COL0:    col = COL_IDLE;
            COL1:    col = {COL_IDLE[2:0], COL_IDLE[3]};
            COL2:    col = {COL_IDLE[1:0], COL_IDLE[3:2]};
            default: col = {COL_IDLE[0], COL_IDLE[3:1]};
        endcase
    end

    // Dwell divider and row capture. frame_done is registered so the
    // debounce stage sees the complete frame in raw one cycle after the
    // column-3 sample; raw cannot change again before the next terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            div        <= '0;
            raw        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (tc) begin
                div                                <= '0;
                raw[{col_idx, 2'b00} +: NUM_ROWS]  <= row_act;
                frame_done                         <= (col_idx == COL3);
            end else begin
                div <= div + DIV_W'(1);
            end
        end
    end

    // Frame-to-frame debounce
    always_comb begin
        match_next = '0;
        if (raw == prev) begin
            match_next = (match == MATCH_LAST) ? match : match + MATCH_W'(1);
        end
        accept   = frame_done && (match_next == MATCH_LAST);
        new_keys = raw & ~acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev           <= '0;
            match          <= '0;
            acc            <= '0;
            kbus.key_code  <= '0;
            kbus.key_valid <= 1'b0;
            kbus.key_down  <= 1'b0;
            kbus.pressed   <= '0;
        end else begin
            kbus.key_valid <= 1'b0;
            if (frame_done) begin
                prev  <= raw;
                match <= match_next;
            end
            if (accept) begin
                acc           <= raw;
                kbus.pressed  <= map_keys(raw);
                kbus.key_down <= |raw;
                if (|new_keys) begin
                    kbus.key_valid <= 1'b1;
                    kbus.key_code  <= key_hex(lowest_set(new_keys));
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    localparam int DEB = 3;

    logic        clk;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] keys;

    keypad_scanner_if kif();

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .row  (row),
        .col  (col),
        .kbus (kif)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int unsigned key_hex_tb [16] = '{1, 4, 7, 0, 2, 5, 8, 15, 3, 6, 9, 14, 10, 11, 12, 13};
    logic [15:0] hist [$];
    logic [15:0] acc;
    logic [15:0] exp_pressed;
    logic [3:0]  exp_code;
    logic        exp_valid;
    logic        exp_down;

    // Event monitor
    int          pulses      = 0;
    logic [3:0]  last_code   = '0;
    logic        prev_v      = 1'b0;
    logic        double_seen = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal keypad: a row reads low when a held key joins it to the driven column
    initial begin
        forever begin
            row = 4'hF;
            for (int c = 0; c < 4; c++) begin
                if (col[c] === 1'b0) begin
                    for (int r = 0; r < 4; r++) begin
                        if (keys[c * 4 + r]) row[r] = 1'b0;
                    end
                end
            end
            @(col or keys);
        end
    end

    always @(negedge clk) begin
        if (kif.key_valid === 1'b1) begin
            pulses++;
            last_code = kif.key_code;
            if (prev_v) double_seen = 1'b1;
        end
        prev_v = (kif.key_valid === 1'b1);
    end

    task automatic model_reset();
        hist.delete();
        hist.push_back(16'h0000);
        acc         = '0;
        exp_pressed = '0;
        exp_code    = '0;
        exp_valid   = 1'b0;
        exp_down    = 1'b0;
    endtask

    // A frame is accepted when the last DEB frames (including the all-clear
    // frame implied by reset) are identical.
    task automatic model_frame(input logic [15:0] k);
        logic        all_eq;
        logic [15:0] newk;
        hist.push_back(k);
        if (hist.size() > DEB) hist.delete(0);
        all_eq = (hist.size() == DEB);
        foreach (hist[i]) if (hist[i] != k) all_eq = 1'b0;
        exp_valid = 1'b0;
        if (all_eq) begin
            newk = k & ~acc;
            acc  = k;
            exp_pressed = '0;
            for (int i = 0; i < 16; i++) if (k[i]) exp_pressed[key_hex_tb[i]] = 1'b1;
            exp_down = (k != 16'h0000);
            if (newk != 16'h0000) begin
                exp_valid = 1'b1;
                for (int i = 15; i >= 0; i--) if (newk[i]) exp_code = 4'(key_hex_tb[i]);
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        vectors++; if (col !== 4'b1110) begin miscompares++; $display("FAIL reset_col: got %b expected 1110", col); end
        vectors++; if (kif.key_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", kif.key_valid); end
        vectors++; if (kif.key_code !== 4'h0) begin miscompares++; $display("FAIL reset_code: got %h expected 0", kif.key_code); end
        vectors++; if (kif.pressed !== 16'h0000) begin miscompares++; $display("FAIL reset_pressed: got %h expected 0000", kif.pressed); end
        vectors++; if (kif.key_down !== 1'b0) begin miscompares++; $display("FAIL reset_down: got %b expected 0", kif.key_down); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One 16-cycle frame with keys held; checks every cycle against the
    // result of the previous frame, then advances the model.
    task automatic step_frame(input logic [15:0] k);
        logic [3:0] exp_col;
        logic       ev;
        keys = k;
        for (int j = 0; j < 16; j++) begin
            @(posedge clk);
            #1;
            exp_col = ~(4'b0001 << (((j + 1) / 4) % 4));
            ev      = (j == 0) ? exp_valid : 1'b0;
            vectors++; if (col !== exp_col) begin miscompares++; $display("FAIL col: got %b expected %b", col, exp_col); end
            vectors++; if (kif.key_valid !== ev) begin miscompares++; $display("FAIL key_valid: got %b expected %b (cycle %0d)", kif.key_valid, ev, j); end
            vectors++; if (kif.key_code !== exp_code) begin miscompares++; $display("FAIL key_code: got %h expected %h", kif.key_code, exp_code); end
            vectors++; if (kif.pressed !== exp_pressed) begin miscompares++; $display("FAIL pressed: got %h expected %h", kif.pressed, exp_pressed); end
            vectors++; if (kif.key_down !== exp_down) begin miscompares++; $display("FAIL key_down: got %b expected %b", kif.key_down, exp_down); end
        end
        model_frame(k);
    endtask

    task automatic test_reset();
        int p0;
        do_reset(3);
        p0 = pulses;
        repeat (10) step_frame(16'h0000);
        vectors++; if (pulses != p0) begin miscompares++; $display("FAIL idle_pulses: got %0d expected 0", pulses - p0); end
    endtask

    task automatic test_single_press();
        int p0;
        p0 = pulses;
        repeat (4) step_frame(16'h0001);
        vectors++; if (pulses - p0 != 1) begin miscompares++; $display("FAIL single_pulses: got %0d expected 1", pulses - p0); end
        vectors++; if (last_code !== 4'h1) begin miscompares++; $display("FAIL single_code: got %h expected 1", last_code); end
        vectors++; if (kif.pressed !== 16'h0002) begin miscompares++; $display("FAIL single_pressed: got %h expected 0002", kif.pressed); end
        repeat (4) step_frame(16'h0000);
        vectors++; if (pulses - p0 != 1) begin miscompares++; $display("FAIL release_pulses: got %0d expected 1", pulses - p0); end
        vectors++; if (kif.key_down !== 1'b0) begin miscompares++; $display("FAIL release_down: got %b expected 0", kif.key_down); end
    endtask

    task automatic test_bounce();
        int p0;
        p0 = pulses;
        for (int n = 0; n < 6; n++) step_frame((n % 2 == 0) ? 16'h0020 : 16'h0000);
        vectors++; if (pulses != p0) begin miscompares++; $display("FAIL bounce_pulses: got %0d expected 0", pulses - p0); end
        repeat (3) step_frame(16'h0020);
        vectors++; if (pulses != p0) begin miscompares++; $display("FAIL bounce_early: got %0d expected 0", pulses - p0); end
        step_frame(16'h0020);
        vectors++; if (pulses - p0 != 1) begin miscompares++; $display("FAIL bounce_hold: got %0d expected 1", pulses - p0); end
        vectors++; if (last_code !== 4'h5) begin miscompares++; $display("FAIL bounce_code: got %h expected 5", last_code); end
        repeat (4) step_frame(16'h0000);
    endtask

    task automatic test_simultaneous();
        int p0;
        p0 = pulses;
        repeat (4) step_frame(16'h8010);
        vectors++; if (pulses - p0 != 1) begin miscompares++; $display("FAIL simul_pulses: got %0d expected 1", pulses - p0); end
        vectors++; if (last_code !== 4'h2) begin miscompares++; $display("FAIL simul_code: got %h expected 2", last_code); end
        vectors++; if (kif.pressed !== 16'h2004) begin miscompares++; $display("FAIL simul_pressed: got %h expected 2004", kif.pressed); end
        repeat (4) step_frame(16'h8000);
        vectors++; if (pulses - p0 != 1) begin miscompares++; $display("FAIL partial_release_pulses: got %0d expected 1", pulses - p0); end
        vectors++; if (kif.pressed !== 16'h2000) begin miscompares++; $display("FAIL partial_release_pressed: got %h expected 2000", kif.pressed); end
        repeat (4) step_frame(16'h0000);
    endtask

    task automatic test_repress();
        int p0;
        p0 = pulses;
        repeat (4) step_frame(16'h0800);
        repeat (4) step_frame(16'h0000);
        repeat (4) step_frame(16'h0800);
        vectors++; if (pulses - p0 != 2) begin miscompares++; $display("FAIL repress_pulses: got %0d expected 2", pulses - p0); end
        vectors++; if (last_code !== 4'hE) begin miscompares++; $display("FAIL repress_code: got %h expected e", last_code); end
        repeat (4) step_frame(16'h0000);
    endtask

    task automatic test_midscan_reset();
        int p0;
        do_reset(2);
        repeat (2) step_frame(16'h0400);
        repeat (9) @(posedge clk);
        do_reset(2);
        p0 = pulses;
        repeat (3) step_frame(16'h0400);
        vectors++; if (pulses != p0) begin miscompares++; $display("FAIL midscan_early: got %0d expected 0", pulses - p0); end
        step_frame(16'h0400);
        vectors++; if (pulses - p0 != 1) begin miscompares++; $display("FAIL midscan_pulses: got %0d expected 1", pulses - p0); end
        vectors++; if (last_code !== 4'h9) begin miscompares++; $display("FAIL midscan_code: got %h expected 9", last_code); end
        vectors++; if (kif.pressed !== 16'h0200) begin miscompares++; $display("FAIL midscan_pressed: got %h expected 0200", kif.pressed); end
        repeat (4) step_frame(16'h0000);
    endtask

    task automatic test_random();
        logic [15:0] k;
        k = '0;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                k = '0;
                repeat ($urandom_range(0, 2)) k[$urandom_range(0, 15)] = 1'b1;
            end
            step_frame(k);
        end
        repeat (4) step_frame(16'h0000);
    endtask

    task automatic test_back_to_back();
        vectors++; if (double_seen !== 1'b0) begin miscompares++; $display("FAIL back_to_back: got %b expected 0", double_seen); end
    endtask

    initial begin
        rst  = 1'b1;
        keys = '0;
        model_reset();
        test_reset();
        test_single_press();
        test_bounce();
        test_simultaneous();
        test_repress();
        test_midscan_reset();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
